// File: rtl/mvm_result_collector.sv
// rtl/mvm_result_collector.sv - captures K-word result bursts after done and queues them in a FIFO
// Optional MVM_COLLECT_RELU_EN clamps negative words to zero as they are written into the FIFO.
// res_in is always staged one cycle, so the FSM's CAPTURE cycles are the FIFO write cycles.

module mvm_result_collector #(
   parameter int K     = 4,
   parameter int B     = 8,
   parameter int DEPTH = 8,
   parameter int SKIP  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         done,
   input  logic signed [2*B-1:0]        res_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [2*B-1:0]        out_data,
   output logic                         out_last,
   output logic                         busy,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int W  = 2 * B;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(SKIP + 2);
   localparam int IW = $clog2(K + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

   state_t              state_q;
   logic [SW-1:0]       skip_q;
   logic [IW-1:0]       idx_q;
   logic                busy_q;
   logic signed [W-1:0] res_q;

   logic [W:0]          mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;

   logic                push_req, push, pop;
   logic signed [W-1:0] word;
   logic                word_last;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         skip_q  <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (done) begin
                  idx_q  <= '0;
                  busy_q <= 1'b1;
                  if (SKIP == 0) begin
                     state_q <= S_CAPTURE;
                  end else begin
                     state_q <= S_WAIT;
                     skip_q  <= SW'(1);
                  end
               end
            end
            S_WAIT: begin
               if (skip_q == SW'(SKIP)) begin
                  state_q <= S_CAPTURE;
               end else begin
                  skip_q <= skip_q + 1'b1;
               end
            end
            S_CAPTURE: begin
               if (idx_q == IW'(K - 1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q <= '0;
      end else begin
         res_q <= res_in;
      end
   end

   always_comb begin
`ifdef MVM_COLLECT_RELU_EN
      word = res_q[W-1] ? '0 : res_q;
`else
      word = res_q;
`endif
      word_last = (idx_q == IW'(K - 1));
   end

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   always_comb begin
      pop        = (count_q != '0) && out_ready;
      push_req   = (state_q == S_CAPTURE);
      push       = push_req && ((count_q != CW'(DEPTH)) || pop);
      overflow_d = overflow_q | (push_req & ~push);
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {word_last, word};
      end
   end

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q][W-1:0] : '0;
   assign out_last  = out_valid & mem_q[rd_ptr_q][W];
   assign busy      = busy_q;
   assign overflow  = overflow_q;
   assign count     = count_q;

endmodule
